gpio_apb_arbiter: RTL and testbench

Two-requester APB arbiter placed in front of the GPIO APB completer (LED, switch and 7-segment registers), so that the CPU bus bridge and a second requester (debug/DMA port) share the peripheral. It serialises transfers with round-robin fairness, forwards exactly one APB transfer at a time downstream, returns the response only to the granted requester, and terminates hung downstream accesses with a timeout error.

---
 rtl/gpio_apb_arbiter_if.sv | 64 ++++++
 rtl/gpio_apb_arbiter.sv | 126 ++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_apb_arbiter_if.sv
// Bus bundle for the two-requester APB arbiter:
// requester ports m0/m1, downstream APB port and grant.
interface gpio_apb_arbiter_if;
  logic [31:0] m0_paddr;
  logic        m0_psel;
  logic        m0_penable;
  logic [2:0]  m0_pprot;
  logic        m0_pwrite;
  logic [31:0] m0_pwdata;
  logic [3:0]  m0_pstrb;
  logic        m0_pready;
  logic [31:0] m0_prdata;
  logic        m0_pslverr;

  logic [31:0] m1_paddr;
  logic        m1_psel;
  logic        m1_penable;
  logic [2:0]  m1_pprot;
  logic        m1_pwrite;
  logic [31:0] m1_pwdata;
  logic [3:0]  m1_pstrb;
  logic        m1_pready;
  logic [31:0] m1_prdata;
  logic        m1_pslverr;

  logic        out_psel;
  logic        out_penable;
  logic [31:0] out_paddr;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  logic [1:0]  grant;

  modport master (
    output m0_paddr, m0_psel, m0_penable, m0_pprot,
    output m0_pwrite, m0_pwdata, m0_pstrb,
    input  m0_pready, m0_prdata, m0_pslverr,
    output m1_paddr, m1_psel, m1_penable, m1_pprot,
    output m1_pwrite, m1_pwdata, m1_pstrb,
    input  m1_pready, m1_prdata, m1_pslverr,
    input  out_psel, out_penable, out_paddr, out_pprot,
    input  out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr,
    input  grant
  );

  modport slave (
    input  m0_paddr, m0_psel, m0_penable, m0_pprot,
    input  m0_pwrite, m0_pwdata, m0_pstrb,
    output m0_pready, m0_prdata, m0_pslverr,
    input  m1_paddr, m1_psel, m1_penable, m1_pprot,
    input  m1_pwrite, m1_pwdata, m1_pstrb,
    output m1_pready, m1_prdata, m1_pslverr,
    output out_psel, out_penable, out_paddr, out_pprot,
    output out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr,
    output grant
  );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Round-robin two-requester APB arbiter in front of the GPIO
// completer, with downstream timeout error completion.
module gpio_apb_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic              clock,
  input logic              reset_n,
  gpio_apb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t         r_state;
  logic [1:0]     r_grant;
  logic           r_last_m1;
  logic [CW-1:0]  r_cnt;

  logic           w_busy;
  logic           w_access;
  logic           w_timeout;
  logic           w_done;
  logic           w_own_sel;
  logic           w_req;
  logic           w_pick_m0;
  logic           w_rsp;
  logic [31:0]    w_rdata;
  logic           w_err;
  logic           w_unused;

  assign w_unused  = bus.m0_penable ^ bus.m1_penable;

  assign w_busy    = (r_state != S_IDLE);
  assign w_access  = (r_state == S_ACCESS);
  assign w_timeout = (TIMEOUT != 0) && w_access &&
                     !bus.out_pready && (r_cnt == LIMIT);
  assign w_done    = w_access && (bus.out_pready || w_timeout);

  assign w_own_sel = (r_grant[0] & bus.m0_psel) |
                     (r_grant[1] & bus.m1_psel);
  assign w_req     = bus.m0_psel | bus.m1_psel;
  // m0 wins a tie only when m1 was served last
  assign w_pick_m0 = bus.m0_psel && (!bus.m1_psel || r_last_m1);

  // completion pulse is suppressed if the owner let go of psel
  assign w_rsp     = w_done && w_own_sel;
  assign w_rdata   = bus.out_pready ? bus.out_prdata : '0;
  assign w_err     = bus.out_pready ? bus.out_pslverr : 1'b1;

  assign bus.m0_pready  = w_rsp & r_grant[0];
  assign bus.m0_prdata  = (w_rsp & r_grant[0]) ? w_rdata : '0;
  assign bus.m0_pslverr = w_rsp & r_grant[0] & w_err;

  assign bus.m1_pready  = w_rsp & r_grant[1];
  assign bus.m1_prdata  = (w_rsp & r_grant[1]) ? w_rdata : '0;
  assign bus.m1_pslverr = w_rsp & r_grant[1] & w_err;

  assign bus.out_psel    = w_busy;
  assign bus.out_penable = w_access;
  assign bus.grant       = r_grant;

  always_comb begin
    bus.out_paddr  = '0;
    bus.out_pprot  = '0;
    bus.out_pwrite = 1'b0;
    bus.out_pwdata = '0;
    bus.out_pstrb  = '0;
    unique case (1'b1)
      r_grant[0]: begin
        bus.out_paddr  = bus.m0_paddr;
        bus.out_pprot  = bus.m0_pprot;
        bus.out_pwrite = bus.m0_pwrite;
        bus.out_pwdata = bus.m0_pwdata;
        bus.out_pstrb  = bus.m0_pstrb;
      end
      r_grant[1]: begin
        bus.out_paddr  = bus.m1_paddr;
        bus.out_pprot  = bus.m1_pprot;
        bus.out_pwrite = bus.m1_pwrite;
        bus.out_pwdata = bus.m1_pwdata;
        bus.out_pstrb  = bus.m1_pstrb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_last_m1 <= 1'b1;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_grant <= w_pick_m0 ? 2'b01 : 2'b10;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_last_m1 <= r_grant[1];
            r_grant   <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Self-checking bench for gpio_apb_arbiter: directed scenarios
// plus randomized transfers against a transaction-level model.
module tb_gpio_apb_arbiter;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  gpio_apb_arbiter_if bus();

  gpio_apb_arbiter #(.TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [143:0] all_out;
  logic [33:0]  m0_rsp;
  logic [33:0]  m1_rsp;
  logic [71:0]  payload;

  assign m0_rsp = {bus.m0_pready, bus.m0_prdata, bus.m0_pslverr};
  assign m1_rsp = {bus.m1_pready, bus.m1_prdata, bus.m1_pslverr};
  assign payload = {bus.out_paddr, bus.out_pprot, bus.out_pwrite,
                    bus.out_pwdata, bus.out_pstrb};
  assign all_out = {bus.grant, bus.out_psel, bus.out_penable,
                    payload, m0_rsp, m1_rsp};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.m0_paddr = '0; bus.m0_psel = 0; bus.m0_penable = 0;
    bus.m0_pprot = '0; bus.m0_pwrite = 0; bus.m0_pwdata = '0;
    bus.m0_pstrb = '0;
    bus.m1_paddr = '0; bus.m1_psel = 0; bus.m1_penable = 0;
    bus.m1_pprot = '0; bus.m1_pwrite = 0; bus.m1_pwdata = '0;
    bus.m1_pstrb = '0;
    bus.out_pready = 0; bus.out_prdata = '0; bus.out_pslverr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    bus.m0_psel = 1;
    bus.m1_psel = 1;
    step();
    smp();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    step();
    smp();
    checks++;
    if (bus.grant !== 2'b00) begin
      errors++;
      $display("FAIL reset_grant got=%b exp=00", bus.grant);
    end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    bus.m0_psel = 1; bus.m0_paddr = 32'h0;
    bus.m0_pwrite = 1; bus.m0_pwdata = 32'h0000A5A5;
    bus.m0_pstrb = 4'h3;
    bus.out_pready = 1;
    smp();
    checks++;
    if ({bus.out_psel, bus.grant, bus.m0_pready} !== 4'b0) begin
      errors++;
      $display("FAIL wr_T got=%b exp=0000",
               {bus.out_psel, bus.grant, bus.m0_pready});
    end
    step(); smp();
    checks++;
    if ({bus.out_psel, bus.out_penable, bus.grant, bus.m0_pready}
        !== 5'b10010) begin
      errors++;
      $display("FAIL wr_T1 got=%b exp=10010",
               {bus.out_psel, bus.out_penable, bus.grant,
                bus.m0_pready});
    end
    checks++;
    if (payload !== {32'h0, 3'h0, 1'b1, 32'h0000A5A5, 4'h3}) begin
      errors++;
      $display("FAIL wr_payload got=%h", payload);
    end
    step(); smp();
    checks++;
    if ({bus.out_penable, bus.grant, bus.m0_pready} !== 4'b1011) begin
      errors++;
      $display("FAIL wr_T2 got=%b exp=1011",
               {bus.out_penable, bus.grant, bus.m0_pready});
    end
    checks++;
    if (m1_rsp !== '0) begin
      errors++;
      $display("FAIL wr_m1_quiet got=%h exp=0", m1_rsp);
    end
    step();
    bus.m0_psel = 0;
    smp();
    checks++;
    if ({bus.out_psel, bus.grant, bus.m0_pready} !== 4'b0) begin
      errors++;
      $display("FAIL wr_T3 got=%b exp=0000",
               {bus.out_psel, bus.grant, bus.m0_pready});
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    do_reset();
    bus.m0_psel = 1;
    bus.m1_psel = 1;
    bus.out_pready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      smp();
      step(); smp();
      checks++;
      if (bus.grant !== exp_g) begin
        errors++;
        $display("FAIL tie_grant%0d got=%b exp=%b", i, bus.grant, exp_g);
      end
      step(); smp();
      checks++;
      if ({bus.m1_pready, bus.m0_pready} !== exp_g) begin
        errors++;
        $display("FAIL tie_pready%0d got=%b exp=%b", i,
                 {bus.m1_pready, bus.m0_pready}, exp_g);
      end
      step();
    end
  endtask

  task automatic test_read_m1();
    do_reset();
    bus.m1_psel = 1; bus.m1_paddr = 32'h4; bus.m1_pwrite = 0;
    bus.out_pready = 1; bus.out_prdata = 32'h0000BEEF;
    step(); smp();
    checks++;
    if ({bus.grant, bus.out_paddr, bus.out_pwrite}
        !== {2'b10, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL rd_setup got=%b/%h/%b exp=10/4/0",
               bus.grant, bus.out_paddr, bus.out_pwrite);
    end
    step(); smp();
    checks++;
    if (m1_rsp !== {1'b1, 32'h0000BEEF, 1'b0}) begin
      errors++;
      $display("FAIL rd_m1 got=%h exp=%h", m1_rsp,
               {1'b1, 32'h0000BEEF, 1'b0});
    end
    checks++;
    if (m0_rsp !== '0) begin
      errors++;
      $display("FAIL rd_m0_quiet got=%h exp=0", m0_rsp);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.m0_psel = 1; bus.m0_paddr = 32'h8;
    bus.out_pready = 0; bus.out_prdata = 32'hDEAD0001;
    bus.out_pslverr = 0;
    step(); smp();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step(); smp();
      n = i;
      if (bus.m0_pready === 1'b1) break;
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL to_cycles got=%0d exp=%0d", n, TO);
    end
    checks++;
    if (m0_rsp !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL to_resp got=%h exp=%h", m0_rsp,
               {1'b1, 32'h0, 1'b1});
    end
    step();
    bus.m0_psel = 0;
    smp();
    checks++;
    if ({bus.out_psel, bus.out_penable, bus.grant} !== 4'b0) begin
      errors++;
      $display("FAIL to_idle got=%b exp=0000",
               {bus.out_psel, bus.out_penable, bus.grant});
    end
  endtask

  task automatic test_wait_err();
    do_reset();
    bus.m1_psel = 1; bus.m1_paddr = 32'hC;
    bus.out_prdata = 32'h12345678;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.out_pready = (k == 4);
      bus.out_pslverr = (k == 4);
      smp();
      checks++;
      if (bus.m1_pready !== (k == 4)) begin
        errors++;
        $display("FAIL wait_pready%0d got=%b exp=%b", k,
                 bus.m1_pready, (k == 4));
      end
    end
    checks++;
    if (m1_rsp !== {1'b1, 32'h12345678, 1'b1}) begin
      errors++;
      $display("FAIL wait_err got=%h exp=%h", m1_rsp,
               {1'b1, 32'h12345678, 1'b1});
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.m0_psel = 1; bus.m0_paddr = 32'h10;
    step(); step(); step();
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL midrst_async got=%h exp=0", all_out);
    end
    bus.m1_psel = 1;
    bus.out_pready = 1;
    step(); smp();
    checks++;
    if ({bus.m0_pready, bus.m1_pready, bus.grant} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_hold got=%b exp=0000",
               {bus.m0_pready, bus.m1_pready, bus.grant});
    end
    step();
    reset_n = 1;
    step(); smp();
    checks++;
    if (bus.grant !== 2'b01) begin
      errors++;
      $display("FAIL midrst_tie got=%b exp=01", bus.grant);
    end
  endtask

  task automatic test_psel_drop();
    do_reset();
    bus.m0_psel = 1;
    bus.out_pready = 1;
    step();
    bus.m0_psel = 0;
    step(); smp();
    checks++;
    if ({bus.out_penable, bus.m0_pready} !== 2'b10) begin
      errors++;
      $display("FAIL drop_gate got=%b exp=10",
               {bus.out_penable, bus.m0_pready});
    end
    step();
    bus.m0_psel = 1;
    bus.m1_psel = 1;
    step(); smp();
    checks++;
    if (bus.grant !== 2'b10) begin
      errors++;
      $display("FAIL drop_last got=%b exp=10", bus.grant);
    end
  endtask

  task automatic test_random(input int n);
    bit          pend [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  s [2];
    logic [2:0]  pr [2];
    logic        w [2];
    int          lastm, own, wt, rd;
    logic        err, fin;
    logic [33:0] exp_rsp;
    do_reset();
    lastm = 1;
    pend[0] = 0;
    pend[1] = 0;
    repeat (n) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 2) != 0 || (r == 1 && !pend[0]))) begin
          pend[r] = 1;
          a[r] = $urandom; d[r] = $urandom;
          s[r] = 4'($urandom); pr[r] = 3'($urandom);
          w[r] = 1'($urandom);
        end
      end
      if (pend[0] && pend[1]) own = (lastm == 0) ? 1 : 0;
      else own = pend[0] ? 0 : 1;
      wt = $urandom_range(0, 19);
      err = 1'($urandom);
      rd = $urandom;
      bus.m0_psel = pend[0]; bus.m0_paddr = a[0]; bus.m0_pwdata = d[0];
      bus.m0_pstrb = s[0]; bus.m0_pprot = pr[0]; bus.m0_pwrite = w[0];
      bus.m1_psel = pend[1]; bus.m1_paddr = a[1]; bus.m1_pwdata = d[1];
      bus.m1_pstrb = s[1]; bus.m1_pprot = pr[1]; bus.m1_pwrite = w[1];
      bus.out_pready = 0;
      smp();
      checks++;
      if ({bus.grant, bus.out_psel} !== 3'b0) begin
        errors++;
        $display("FAIL rnd_idle got=%b exp=000",
                 {bus.grant, bus.out_psel});
      end
      step(); smp();
      checks++;
      if ({bus.grant, bus.out_psel, bus.out_penable} !==
          {(own == 1), (own == 0), 2'b10}) begin
        errors++;
        $display("FAIL rnd_setup got=%b own=%0d",
                 {bus.grant, bus.out_psel, bus.out_penable}, own);
      end
      checks++;
      if (payload !== {a[own], pr[own], w[own], d[own], s[own]}) begin
        errors++;
        $display("FAIL rnd_payload got=%h exp=%h", payload,
                 {a[own], pr[own], w[own], d[own], s[own]});
      end
      for (int k = 0; k < 40; k++) begin
        step();
        bus.out_pready = (k == wt);
        bus.out_prdata = (k == wt) ? rd : $urandom;
        bus.out_pslverr = (k == wt) ? err : 1'($urandom);
        smp();
        fin = (k == wt) || (k == TO - 1);
        if (!fin) exp_rsp = '0;
        else if (k == wt) exp_rsp = {1'b1, rd[31:0], err};
        else exp_rsp = {1'b1, 32'h0, 1'b1};
        checks++;
        if ((own == 0 ? m0_rsp : m1_rsp) !== exp_rsp ||
            (own == 0 ? m1_rsp : m0_rsp) !== '0 ||
            bus.out_penable !== 1'b1) begin
          errors++;
          $display("FAIL rnd_access k=%0d wt=%0d own=%0d m0=%h m1=%h exp=%h",
                   k, wt, own, m0_rsp, m1_rsp, exp_rsp);
        end
        if (fin) break;
      end
      lastm = own;
      pend[own] = 0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_tie();
    test_read_m1();
    test_timeout();
    test_wait_err();
    test_reset_mid_access();
    test_psel_drop();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
